dmem_responder: RTL

Memory-side responder for the core's data load/store interface. It accepts one request at a time through a valid/ready handshake. It services the request from an internal word-organised RAM after a configurable wait-state latency. It then returns a response through a second valid/ready handshake. It sits between the datapath's address/write-data/read-data path and the backing storage, and it models realistic multi-cycle memory timing.

---
 rtl/dmem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait-state latency,
// word-organised RAM with byte-enable stores and registered load data.
module dmem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LAT   = 2,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic           err_q, err_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           rerr_q, rerr_d;

  logic [31:0]    mem [DEPTH];

  logic [31:0]    off;
  logic           dec_err;
  logic [AW-1:0]  dec_idx;
  logic           accept;

  // BASE is word-aligned, so off[1:0] equals req_addr[1:0].
  assign off     = req_addr - BASE;
  assign dec_err = (off[1:0] != 2'b00) || ({2'b00, off[31:2]} >= 32'(DEPTH));
  assign dec_idx = off[AW+1:2];

  assign req_ready = reset && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d  = req_we;
          err_d = dec_err;
          idx_d = dec_idx;
          if (LAT == 1) begin
            // Single-cycle latency: the load reads straight from the decoded request.
            state_d = RESP;
            rdata_d = (!req_we && !dec_err) ? mem[dec_idx] : '0;
            rerr_d  = dec_err;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LAT - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rdata_d = (!we_q && !err_q) ? mem[idx_q] : '0;
          rerr_d  = err_q;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          rerr_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Storage is not reset; stores commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && !dec_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_be[b]) mem[dec_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule
